// File: rtl/launcher_pkg.sv
// Shared types and defaults for the program launcher.
// Contents:
//   launcher_state_e - FSM states IDLE, RST, START, WAIT_ACK, FIN
//   DefRstCycles, DefStartCycles, DefTimeout - parameter defaults
//   TimeoutMarker    - value recorded in the cycle log for a timed-out run
package launcher_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StStart,
    StWaitAck,
    StFin
  } launcher_state_e;

  localparam int unsigned DefRstCycles   = 2;
  localparam int unsigned DefStartCycles = 4;
  localparam int unsigned DefTimeout     = 4096;

  localparam logic [15:0] TimeoutMarker = 16'hFFFF;

endpackage

// File: rtl/launcher_cycle_counter.sv
// Saturating 16-bit WAIT_ACK cycle counter.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   clr             - synchronous clear to zero (wins over en)
//   en              - increment by one this cycle
//   limit           - run limit (1..65535)
//   count           - current count
//   at_limit        - the increment taken this cycle brings count to limit
module launcher_cycle_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] limit,
  output logic [15:0] count,
  output logic        at_limit
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  // Look-ahead so the FSM can leave WAIT_ACK on the same edge that count reaches limit.
  assign at_limit = (count_q == (limit - 16'd1));

endmodule

// File: rtl/program_launcher.sv
// Launches one processor program run: reset pulse, start pulse, then waits for
// an acknowledge or a timeout and reports the elapsed WAIT_ACK cycle count.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   go, prog_sel         - launch request and program index (sampled in IDLE)
//   dut_reset, dut_start - reset and start drives to the processor
//   dut_ack              - processor completion
//   busy, done           - not-idle flag, one-cycle completion strobe
//   timeout, cycles      - last run outcome, held until the next launch
//   prog_id              - program index latched at launch
// Optional build macro CYCLE_LOG_EN adds log_idx / log_cycles: a 4-entry
// per-program log of the last cycle count (TimeoutMarker on timeout).
module program_launcher
  import launcher_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = DefRstCycles,
  parameter int unsigned START_CYCLES = DefStartCycles,
  parameter int unsigned TIMEOUT      = DefTimeout
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [1:0]  prog_sel,
  output logic        dut_reset,
  output logic        dut_start,
  input  logic        dut_ack,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycles,
  output logic [1:0]  prog_id
`ifdef CYCLE_LOG_EN
  ,
  input  logic [1:0]  log_idx,
  output logic [15:0] log_cycles
`endif
);

  localparam logic [15:0] RstLast   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] StartLast = 16'(START_CYCLES - 1);
  localparam logic [15:0] Limit     = 16'(TIMEOUT);

  launcher_state_e state_q, state_d;
  logic [15:0]     phase_q, phase_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      prog_id_q, prog_id_d;
  logic            rst_hold_q;
  logic            cnt_clr, cnt_en, cnt_at_limit;
  logic [15:0]     cnt_count;

  launcher_cycle_counter u_cycle_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .limit    (Limit),
    .count    (cnt_count),
    .at_limit (cnt_at_limit)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    timeout_d = timeout_q;
    prog_id_d = prog_id_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d   = StRst;
          phase_d   = '0;
          timeout_d = 1'b0;
          prog_id_d = prog_sel;
          cnt_clr   = 1'b1;
        end
      end
      StRst: begin
        if (phase_q == RstLast) begin
          state_d = StStart;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      StStart: begin
        if (phase_q == StartLast) begin
          state_d = StWaitAck;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      StWaitAck: begin
        cnt_en = 1'b1;
        // Ack takes priority over a limit reached on the same cycle.
        if (dut_ack) begin
          state_d = StFin;
        end else if (cnt_at_limit) begin
          state_d   = StFin;
          timeout_d = 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      timeout_q  <= 1'b0;
      prog_id_q  <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      timeout_q  <= timeout_d;
      prog_id_q  <= prog_id_d;
      rst_hold_q <= 1'b0;
    end
  end

  // rst_hold_q keeps the processor in reset while we are, until the first edge after release.
  assign dut_reset = rst_hold_q | (state_q == StRst);
  assign dut_start = (state_q == StStart);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign timeout   = timeout_q;
  assign cycles    = cnt_count;
  assign prog_id   = prog_id_q;

`ifdef CYCLE_LOG_EN
  logic [15:0] log_q [4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        log_q[i] <= '0;
      end
    end else if (state_q == StFin) begin
      log_q[prog_id_q] <= timeout_q ? TimeoutMarker : cnt_count;
    end
  end

  assign log_cycles = log_q[log_idx];
`endif

endmodule

// File: tb/tb_program_launcher.sv
// Three launchers (TIMEOUT 4096, 16, 8) share one stimulus stream; a
// launch-relative timing model predicts every output each cycle.
module tb_program_launcher;

  localparam int unsigned R  = 2;
  localparam int unsigned S  = 4;
  localparam int          NI = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic       dut_ack = 1'b0;
  logic [1:0] prog_sel = 2'd0;

  logic        busy_w   [NI];
  logic        done_w   [NI];
  logic        dres_w   [NI];
  logic        dstart_w [NI];
  logic        tmo_w    [NI];
  logic [15:0] cyc_w    [NI];
  logic [1:0]  pid_w    [NI];
`ifdef CYCLE_LOG_EN
  logic [1:0]  log_idx = 2'd0;
  logic [15:0] log_w [NI];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_launcher #(.RST_CYCLES(R), .START_CYCLES(S), .TIMEOUT(4096)) u_dut_a (
    .clk(clk), .reset(reset), .go(go), .prog_sel(prog_sel), .dut_reset(dres_w[0]),
    .dut_start(dstart_w[0]), .dut_ack(dut_ack), .busy(busy_w[0]), .done(done_w[0]),
    .timeout(tmo_w[0]), .cycles(cyc_w[0]), .prog_id(pid_w[0])
`ifdef CYCLE_LOG_EN
    , .log_idx(log_idx), .log_cycles(log_w[0])
`endif
  );

  program_launcher #(.RST_CYCLES(R), .START_CYCLES(S), .TIMEOUT(16)) u_dut_b (
    .clk(clk), .reset(reset), .go(go), .prog_sel(prog_sel), .dut_reset(dres_w[1]),
    .dut_start(dstart_w[1]), .dut_ack(dut_ack), .busy(busy_w[1]), .done(done_w[1]),
    .timeout(tmo_w[1]), .cycles(cyc_w[1]), .prog_id(pid_w[1])
`ifdef CYCLE_LOG_EN
    , .log_idx(log_idx), .log_cycles(log_w[1])
`endif
  );

  program_launcher #(.RST_CYCLES(R), .START_CYCLES(S), .TIMEOUT(8)) u_dut_c (
    .clk(clk), .reset(reset), .go(go), .prog_sel(prog_sel), .dut_reset(dres_w[2]),
    .dut_start(dstart_w[2]), .dut_ack(dut_ack), .busy(busy_w[2]), .done(done_w[2]),
    .timeout(tmo_w[2]), .cycles(cyc_w[2]), .prog_id(pid_w[2])
`ifdef CYCLE_LOG_EN
    , .log_idx(log_idx), .log_cycles(log_w[2])
`endif
  );

  function automatic int unsigned tmo_of(input int i);
    case (i)
      0:       return 4096;
      1:       return 16;
      default: return 8;
    endcase
  endfunction

  // Model: m_n counts cycles since launch (1 = first reset cycle); the wait
  // cycle number is m_n - R - S. m_fin marks the single done cycle.
  bit          m_hold = 1'b1;
  bit          m_busy  [NI];
  bit          m_fin   [NI];
  int unsigned m_n     [NI];
  int unsigned m_final [NI];
  bit          m_tmo   [NI];
  logic [1:0]  m_prog  [NI];
`ifdef CYCLE_LOG_EN
  int unsigned m_log [NI][4];
`endif

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hold <= 1'b1;
      for (int i = 0; i < NI; i++) begin
        m_busy[i]  <= 1'b0;
        m_fin[i]   <= 1'b0;
        m_n[i]     <= 0;
        m_final[i] <= 0;
        m_tmo[i]   <= 1'b0;
        m_prog[i]  <= 2'd0;
`ifdef CYCLE_LOG_EN
        for (int j = 0; j < 4; j++) m_log[i][j] <= 0;
`endif
      end
    end else begin
      m_hold <= 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (m_fin[i]) begin
`ifdef CYCLE_LOG_EN
          m_log[i][m_prog[i]] <= m_tmo[i] ? 32'hFFFF : m_final[i];
`endif
          m_fin[i]  <= 1'b0;
          m_busy[i] <= 1'b0;
        end else if (m_busy[i]) begin
          if (m_n[i] > R + S && (dut_ack || (m_n[i] - R - S == tmo_of(i)))) begin
            m_fin[i]   <= 1'b1;
            m_final[i] <= m_n[i] - R - S;
            m_tmo[i]   <= !dut_ack;
          end else begin
            m_n[i] <= m_n[i] + 1;
          end
        end else if (go) begin
          m_busy[i]  <= 1'b1;
          m_n[i]     <= 1;
          m_prog[i]  <= prog_sel;
          m_final[i] <= 0;
          m_tmo[i]   <= 1'b0;
        end
      end
    end
  end

  function automatic bit e_dres(input int i);
    return m_hold || (m_busy[i] && !m_fin[i] && m_n[i] <= R);
  endfunction

  function automatic bit e_dstart(input int i);
    return m_busy[i] && !m_fin[i] && m_n[i] > R && m_n[i] <= R + S;
  endfunction

  function automatic int unsigned e_cyc(input int i);
    if (!m_busy[i] || m_fin[i]) return m_final[i];
    return (m_n[i] > R + S) ? m_n[i] - R - S - 1 : 0;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, inst, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
      check("done", i, 32'(done_w[i]), 32'(m_fin[i]));
      check("dut_reset", i, 32'(dres_w[i]), 32'(e_dres(i)));
      check("dut_start", i, 32'(dstart_w[i]), 32'(e_dstart(i)));
      check("timeout", i, 32'(tmo_w[i]), 32'(m_tmo[i]));
      check("cycles", i, 32'(cyc_w[i]), e_cyc(i));
      check("prog_id", i, 32'(pid_w[i]), 32'(m_prog[i]));
`ifdef CYCLE_LOG_EN
      check("log_cycles", i, 32'(log_w[i]), m_log[i][log_idx]);
`endif
    end
  end

  int n_dres, n_dstart, n_done;

  // Called at negedge+1; launches with go, then drives ack over launch-relative cycles
  // [ack_from, ack_to] and a stray go on cycle go_at. Counts instance A pulses.
  task automatic run_prog(input logic [1:0] sel, input int ack_from, input int ack_to,
                          input int go_at, input int total);
    n_dres = 0; n_dstart = 0; n_done = 0;
    go = 1'b1;
    prog_sel = sel;
    for (int n = 1; n <= total; n++) begin
      @(negedge clk);
      n_dres   += int'(dres_w[0]);
      n_dstart += int'(dstart_w[0]);
      n_done   += int'(done_w[0]);
      #1;
      go      = (n == go_at);
      dut_ack = (n >= ack_from && n <= ack_to);
    end
    go = 1'b0;
    dut_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_dut_reset", 0, 32'(dres_w[0]), 1);
    check("rst_dut_start", 0, 32'(dstart_w[0]), 0);
    check("rst_busy", 0, 32'(busy_w[0]), 0);
    check("rst_cycles", 0, 32'(cyc_w[0]), 0);
    reset = 1'b1;
    @(negedge clk); #1;
    check("rel_dut_reset", 0, 32'(dres_w[0]), 0);

    // Ack on wait cycle 37 (launch cycle 43).
    run_prog(2'd2, 43, 43, 0, 47);
    check("n_dut_reset", 0, n_dres, 2);
    check("n_dut_start", 0, n_dstart, 4);
    check("n_done", 0, n_done, 1);
    check("run1_cycles", 0, 32'(cyc_w[0]), 37);
    check("run1_timeout", 0, 32'(tmo_w[0]), 0);
    check("run1_prog_id", 0, 32'(pid_w[0]), 2);
    check("run1_cycles", 1, 32'(cyc_w[1]), 16);
    check("run1_timeout", 1, 32'(tmo_w[1]), 1);
    check("run1_cycles", 2, 32'(cyc_w[2]), 8);

    // Ack held through START and still high on the first wait cycle.
    run_prog(2'd1, 3, 7, 0, 11);
    for (int i = 0; i < NI; i++) check("run2_cycles", i, 32'(cyc_w[i]), 1);

    // Stray go on wait cycle 3, ack on wait cycle 8 (coincides with C's limit).
    run_prog(2'd3, 14, 14, 9, 18);
    for (int i = 0; i < NI; i++) begin
      check("run3_cycles", i, 32'(cyc_w[i]), 8);
      check("run3_timeout", i, 32'(tmo_w[i]), 0);
      check("run3_busy", i, 32'(busy_w[i]), 0);
    end
    check("run3_prog_id", 0, 32'(pid_w[0]), 3);

    // Prog 1 acked at 20, then prog 3 runs to A's full limit.
    run_prog(2'd1, 26, 26, 0, 30);
    check("run4_cycles", 0, 32'(cyc_w[0]), 20);
    run_prog(2'd3, 0, -1, 0, 4106);
    check("run5_cycles", 0, 32'(cyc_w[0]), 4096);
    check("run5_timeout", 0, 32'(tmo_w[0]), 1);
    check("run5_busy", 0, 32'(busy_w[0]), 0);
`ifdef CYCLE_LOG_EN
    log_idx = 2'd1; #1;
    check("log1", 0, 32'(log_w[0]), 20);
    check("log1", 1, 32'(log_w[1]), 32'hFFFF);
    log_idx = 2'd3; #1;
    check("log3", 0, 32'(log_w[0]), 32'hFFFF);
    log_idx = 2'd0; #1;
    check("log0", 0, 32'(log_w[0]), 0);
`endif

    // Reset during wait cycle 5 (launch cycle 11).
    run_prog(2'd1, 0, -1, 0, 11);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("mid_busy", i, 32'(busy_w[i]), 0);
      check("mid_dut_reset", i, 32'(dres_w[i]), 1);
      check("mid_cycles", i, 32'(cyc_w[i]), 0);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("held_dut_reset", 0, 32'(dres_w[0]), 1);
    @(negedge clk); #1;
    check("after_dut_reset", 0, 32'(dres_w[0]), 0);
`ifdef CYCLE_LOG_EN
    log_idx = 2'd1; #1;
    check("log_cleared", 0, 32'(log_w[0]), 0);
`endif
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
